decoder_stream: RTL and testbench
=================================

Name: decoder_stream

Overview:
Parametrised, registered binary-to-one-hot/thermometer decoder with valid/ready flow control. It is the next-generation line decoder: output width is configurable, and it adds a thermometer mode, out-of-range detection and a saturating error counter. It sits between a code source, such as a priority encoder stage, and downstream select/enable logic that can stall.

Parameters:
N_OUT, 12, number of output lines; legal range 2..64.
IN_W, 4, code width; must satisfy 2**IN_W >= N_OUT (elaboration-time check, fatal on violation).
CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_code/in_mode are valid this cycle.
in_ready  output  1  block can accept a code this cycle.
in_code  input  IN_W  binary code to decode.
in_mode  input  1  0 = one-hot, 1 = thermometer; sampled with in_code.
out_valid  output  1  out_data/out_err hold a decoded result.
out_ready  input  1  downstream accepts the result this cycle.
out_data  output  N_OUT  decoded vector.
out_err  output  1  the result came from an out-of-range code.
err_clr  input  1  synchronous clear of err_count.
err_count  output  CNT_W  number of accepted out-of-range codes, saturating.

Behaviour:
- Reset (rst_n low, asynchronous assert): out_valid=0, out_data=0, out_err=0, err_count=0. in_ready reads 1 once out_valid=0. Release is synchronised externally; the block needs no internal synchroniser.
- Reset mid-transfer discards the held result. No output is produced for a code accepted in the reset cycle.
- Single output register stage. in_ready = !out_valid || out_ready (combinational from out_ready only; no combinational path from in_* to out_*).
- Accept when in_valid && in_ready. The result appears on out_data/out_err with out_valid=1 on the next rising edge (latency 1).
- Full throughput: with out_ready held at 1, one code is accepted per cycle.
- Consume when out_valid && out_ready. If no accept happens in the same cycle, out_valid goes to 0 next cycle. If an accept does happen in the same cycle, out_valid stays 1 and the new result replaces the old one.
- Stall: while out_valid && !out_ready, out_data, out_err and out_valid hold stable. in_ready=0 in this state.
- One-hot mode, code < N_OUT: out_data[code]=1, all other bits 0.
- Thermometer mode, code < N_OUT: out_data[code:0] all 1, higher bits 0. Code 0 gives a 1 in bit 0 only. Code N_OUT-1 gives all ones.
- Out-of-range (code >= N_OUT, in either mode): out_data=0 and out_err=1, still delivered as a normal valid result. For in-range codes out_err=0.
- err_count increments by 1 on each accepted out-of-range code and saturates at 2**CNT_W-1 with no wrap.
- err_clr: err_count becomes 0 next cycle. If an out-of-range code is accepted in the same cycle as err_clr, err_count becomes 1, so no event is lost.
- in_code and in_mode are don't-care when in_valid=0. X on in_code while in_valid=0 must not propagate to any output.
- When N_OUT = 2**IN_W, out-of-range is impossible. out_err is constant 0 and err_count stays 0.

Test Plan:
- Reset then default params, out_ready=1: stream codes 0..11 in one-hot mode back-to-back → out_data = 12'h001, 12'h002 … 12'h800 on consecutive cycles, each 1 cycle after accept, out_err=0, in_ready=1 throughout.
- Thermometer mode, codes 0, 5, 11 → 12'h001, 12'h03F, 12'hFFF.
- Codes 12, 15 in each mode → out_data=0, out_err=1, err_count=2 per mode pair (4 total). Then err_clr pulse → err_count=0. err_clr coincident with accepted code 13 → err_count=1.
- Backpressure: accept code 3, hold out_ready=0 for 4 cycles while in_valid=1 with code 7 → out_data stays 12'h008, in_ready=0. Release out_ready → 12'h008 consumed, code 7 accepted that cycle, 12'h080 appears next cycle, no code lost or duplicated.
- Saturation with CNT_W=2: send 5 out-of-range codes → err_count 1, 2, 3, 3, 3.
- Assert rst_n low asynchronously mid-stall with out_valid=1 → outputs zero immediately with no clock edge. After release, the first accepted code decodes correctly with latency 1. Also run with N_OUT=16, IN_W=4: code 15 → 16'h8000, out_err never set.

Source files
------------

// File: rtl/decoder_stream.sv
// decoder_stream: registered binary-to-one-hot / thermometer line decoder
// with valid/ready flow control, out-of-range detection and a saturating
// error counter. A single output register stage gives latency 1 and full
// throughput when the downstream consumer never stalls.
module decoder_stream #(
  parameter int N_OUT = 12,
  parameter int IN_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  // Parameter legality: the code must be able to address every output line,
  // and the output width is bounded to the supported range.
  if ((N_OUT < 2) || (N_OUT > 64)) begin : g_bad_n_out
    $fatal(1, "decoder_stream: N_OUT must lie in 2..64");
  end
  if ((2 ** IN_W) < N_OUT) begin : g_bad_in_w
    $fatal(1, "decoder_stream: 2**IN_W must be >= N_OUT");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $fatal(1, "decoder_stream: CNT_W must be at least 1");
  end

  // One extra bit lets N_OUT itself be represented when N_OUT == 2**IN_W,
  // so the range test below is well defined for every legal parameter set.
  localparam int                EXT_W   = IN_W + 1;
  localparam logic [EXT_W-1:0]  N_LIMIT = EXT_W'(N_OUT);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [EXT_W-1:0] code_ext;
  logic             in_range;
  logic             accept;
  logic             err_event;
  logic [N_OUT-1:0] dec_onehot;
  logic [N_OUT-1:0] dec_therm;
  logic [N_OUT-1:0] dec_next;

  assign code_ext = {1'b0, in_code};

  // The output register can take a new code when it is empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Range test; with a full-width code space this is constantly true.
  assign in_range  = (code_ext < N_LIMIT);
  assign err_event = accept && !in_range;

  // Build both decodings of the incoming code in parallel.
  always_comb begin
    dec_onehot = '0;
    dec_therm  = '0;
    for (int i = 0; i < N_OUT; i++) begin
      dec_onehot[i] = (code_ext == EXT_W'(i));
      dec_therm[i]  = (code_ext >= EXT_W'(i));
    end
  end

  // Pick the decoding for the requested mode; out-of-range codes give zero.
  always_comb begin
    dec_next = '0;
    if (in_range) begin
      dec_next = in_mode ? dec_therm : dec_onehot;
    end
  end

  // Output register: load on accept, drop valid on a consume without refill,
  // and hold everything while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= dec_next;
      out_err   <= !in_range;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating error counter; a clear coincident with an error keeps that error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= err_event ? CNT_W'(1) : '0;
    end else if (err_event && (err_count != CNT_MAX)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decoder_stream.sv
// Self-checking bench for decoder_stream. Three instances share the same
// stimulus: default parameters, a 2-bit error counter, and a full code
// space (N_OUT = 16). A transaction-level reference model predicts every
// output from the decoding rules directly.
module tb_decoder_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_code;
  logic       in_mode;
  logic       out_ready;
  logic       err_clr;

  logic        rdy0, rdy1, rdy2;
  logic        vld0, vld1, vld2;
  logic [11:0] dat0, dat1;
  logic [15:0] dat2;
  logic        err0, err1, err2;
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;
  logic [7:0]  cnt2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state, one entry per instance.
  int          n_out[3]   = '{12, 12, 16};
  int          cnt_max[3] = '{255, 3, 255};
  logic        exp_valid;
  logic [63:0] exp_data[3];
  logic        exp_err[3];
  int          exp_cnt[3];

  always #5 clk = ~clk;

  decoder_stream #(.N_OUT(12), .IN_W(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_code(in_code), .in_mode(in_mode), .out_valid(vld0),
    .out_ready(out_ready), .out_data(dat0), .out_err(err0),
    .err_clr(err_clr), .err_count(cnt0)
  );

  decoder_stream #(.N_OUT(12), .IN_W(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_code(in_code), .in_mode(in_mode), .out_valid(vld1),
    .out_ready(out_ready), .out_data(dat1), .out_err(err1),
    .err_clr(err_clr), .err_count(cnt1)
  );

  decoder_stream #(.N_OUT(16), .IN_W(4), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_code(in_code), .in_mode(in_mode), .out_valid(vld2),
    .out_ready(out_ready), .out_data(dat2), .out_err(err2),
    .err_clr(err_clr), .err_count(cnt2)
  );

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected decoded vector straight from the decoding rules.
  function automatic logic [63:0] refDecode(input int code, input bit mode,
                                            input int n);
    if (code >= n) return 64'd0;
    if (mode) return (64'd2 << code) - 64'd1;
    return 64'd1 << code;
  endfunction

  function automatic logic [63:0] obsData(input int k);
    case (k)
      0:       return 64'(dat0);
      1:       return 64'(dat1);
      default: return 64'(dat2);
    endcase
  endfunction

  function automatic logic [63:0] obsCnt(input int k);
    case (k)
      0:       return 64'(cnt0);
      1:       return 64'(cnt1);
      default: return 64'(cnt2);
    endcase
  endfunction

  function automatic logic obsValid(input int k);
    case (k)
      0:       return vld0;
      1:       return vld1;
      default: return vld2;
    endcase
  endfunction

  function automatic logic obsErr(input int k);
    case (k)
      0:       return err0;
      1:       return err1;
      default: return err2;
    endcase
  endfunction

  function automatic logic obsReady(input int k);
    case (k)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  task automatic modelReset();
    exp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_data[k] = '0;
      exp_err[k]  = 1'b0;
      exp_cnt[k]  = 0;
    end
  endtask

  // Compare all registered outputs of every instance against the model.
  // Data and error flag are only meaningful while a result is held.
  task automatic checkAll(input string tag);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("%s.valid%0d", tag, k), 64'(obsValid(k)), 64'(exp_valid));
      checkOutput($sformatf("%s.count%0d", tag, k), obsCnt(k), 64'(exp_cnt[k]));
      if (exp_valid) begin
        checkOutput($sformatf("%s.data%0d", tag, k), obsData(k), exp_data[k]);
        checkOutput($sformatf("%s.err%0d", tag, k), 64'(obsErr(k)), 64'(exp_err[k]));
      end
    end
  endtask

  // Drive one cycle of inputs, check in_ready, advance the model across the
  // clock edge and check the registered results half a cycle later.
  task automatic applyStimulus(input string tag, input bit v, input logic [3:0] code,
                               input bit mode, input bit ordy, input bit clr);
    bit rdy, acc, oor;
    in_valid  = v;
    in_code   = code;
    in_mode   = mode;
    out_ready = ordy;
    err_clr   = clr;
    #1;
    rdy = !exp_valid || ordy;
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("%s.in_ready%0d", tag, k), 64'(obsReady(k)), 64'(rdy));
    acc = v && rdy;
    for (int k = 0; k < 3; k++) begin
      oor = acc && (int'(code) >= n_out[k]);
      if (clr) exp_cnt[k] = oor ? 1 : 0;
      else if (oor && exp_cnt[k] < cnt_max[k]) exp_cnt[k]++;
      if (acc) begin
        exp_data[k] = refDecode(int'(code), mode, n_out[k]);
        exp_err[k]  = oor;
      end
    end
    if (acc) exp_valid = 1'b1;
    else if (ordy) exp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkAll(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll("reset");
    checkOutput("reset.data0", obsData(0), 64'd0);
    checkOutput("reset.err0", 64'(err0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // One-hot sweep over the in-range codes, back to back.
    for (int c = 0; c < 12; c++) applyStimulus("onehot", 1, 4'(c), 0, 1, 0);
    // Thermometer corner cases.
    applyStimulus("therm0", 1, 4'd0, 1, 1, 0);
    applyStimulus("therm5", 1, 4'd5, 1, 1, 0);
    applyStimulus("therm11", 1, 4'd11, 1, 1, 0);
    applyStimulus("therm15", 1, 4'd15, 1, 1, 0);
    // Out-of-range codes in both modes.
    applyStimulus("oor12h", 1, 4'd12, 0, 1, 0);
    applyStimulus("oor15h", 1, 4'd15, 0, 1, 0);
    applyStimulus("oor12t", 1, 4'd12, 1, 1, 0);
    applyStimulus("oor15t", 1, 4'd15, 1, 1, 0);
    applyStimulus("oor13", 1, 4'd13, 0, 1, 0);
    // Clear alone, then clear coincident with an accepted error.
    applyStimulus("clr", 0, 4'd0, 0, 1, 1);
    applyStimulus("clr13", 1, 4'd13, 0, 1, 1);
    // X on the code while idle must not reach any output.
    applyStimulus("idlex", 0, 4'bxxxx, 1'bx, 1, 0);
    applyStimulus("idlex2", 0, 4'bxxxx, 1'bx, 1, 0);

    // Backpressure: code 3 held for four stalled cycles while 7 waits.
    applyStimulus("bp3", 1, 4'd3, 0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus("bpstall", 1, 4'd7, 0, 0, 0);
    applyStimulus("bprel", 1, 4'd7, 0, 1, 0);
    applyStimulus("bpdrain", 0, 4'd0, 0, 1, 0);

    // Asynchronous reset in the middle of a stall.
    applyStimulus("rs3", 1, 4'd3, 0, 1, 0);
    applyStimulus("rsstall", 1, 4'd7, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("async.valid%0d", k), 64'(obsValid(k)), 64'd0);
      checkOutput($sformatf("async.data%0d", k), obsData(k), 64'd0);
      checkOutput($sformatf("async.err%0d", k), 64'(obsErr(k)), 64'd0);
      checkOutput($sformatf("async.count%0d", k), obsCnt(k), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post9", 1, 4'd9, 0, 1, 0);
    applyStimulus("post15", 1, 4'd15, 0, 1, 0);

    // Randomized traffic with occasional stalls and clears.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", bit'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
                    bit'($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
